mips_prog_loader: RTL and testbench
===================================

// Module: mips_prog_loader
// PURPOSE
//  Boot-time program loader directly upstream of the pipelined MIPS core.
//  Receives a byte stream over a valid/ready handshake, assembles big-endian
//  32-bit instruction words and writes them sequentially into instruction
//  memory from word 0. When the image is complete it asserts cpu_run, which
//  releases the core: HALTED=0, PC=0, TAKEN_BRANCH=0.
// PARAMETERS
//  ADDR_W     10    instruction-memory word-address width
//  MAX_WORDS  1024  largest image accepted; must be <= 2**ADDR_W
// PORTS
//  clk1          in   1       single clock; all state updates on rising edge
//  rst           in   1       asynchronous, active-high reset
//  start         in   1       1-cycle pulse: begin a new load
//  in_byte       in   8       stream byte
//  in_valid      in   1       in_byte is valid
//  in_ready      out  1       loader accepts a byte this cycle
//  mem_we        out  1       instruction-memory write strobe
//  mem_addr      out  ADDR_W  word address of the write
//  mem_wdata     out  32      instruction word
//  word_count    out  16      words written so far in the current load
//  load_done     out  1       image fully written
//  cpu_run       out  1       core released; equals load_done
//  err_overflow  out  1       header count exceeded MAX_WORDS
// BEHAVIOUR
//  - Byte transfer occurs only on a clock edge where in_valid && in_ready.
//  - Stream format: 16-bit big-endian word count N (2 bytes), then N*4 bytes,
//    each word MSB first.
//  - Reset (any time, including mid-load): FSM=IDLE. All outputs 0; internal
//    byte and word counters 0. Memory already written is not erased.
//  - States:
//    IDLE: in_ready=0; start -> HDR_HI.
//    HDR_HI: in_ready=1; take N[15:8] -> HDR_LO.
//    HDR_LO: in_ready=1; take N[7:0]. N==0 -> DONE. N>MAX_WORDS -> ERROR.
//      Otherwise -> DATA.
//    DATA: in_ready=1; shift bytes into the word register. The 4th byte
//      goes to WRITE.
//    WRITE: lasts 1 cycle. in_ready=0, mem_we=1, mem_addr=current index,
//      mem_wdata=assembled word. At the edge ending WRITE, index and
//      word_count increment. Then: word_count==N -> DONE, else -> DATA.
//    DONE: load_done=cpu_run=1; in_ready=0; start -> HDR_HI.
//    ERROR: err_overflow=1; in_ready=0; start -> HDR_HI.
//  - On entering HDR_HI: word_count, index, load_done, cpu_run and
//    err_overflow are cleared to 0.
//  - Latency: the 4th byte of a word is accepted at edge t. mem_we is high
//    in the cycle after t. A new byte cannot be accepted until edge t+2.
//  - load_done rises in the cycle after the last WRITE cycle.
//  - start is ignored in HDR_HI, HDR_LO, DATA and WRITE.
//  - in_valid may drop anywhere in the stream. The FSM holds its state;
//    there is no timeout.
//  - mem_we is only ever high in WRITE, so mem_addr never exceeds N-1 and
//    there is no wrap-around.
//  - All outputs are registered. mem_addr/mem_wdata are don't-care when
//    mem_we=0.
// TESTING
//  1 start; bytes 00 02 28 01 00 0a 28 02 00 14, in_valid held high ->
//    writes addr0=2801000a, addr1=28020014; then load_done=cpu_run=1,
//    word_count=2.
//  2 start; bytes 00 00 -> DONE in the cycle after the header; mem_we never
//    asserted; word_count=0.
//  3 start; bytes 04 01 (N=1025) -> err_overflow=1, in_ready=0; further
//    in_valid is not accepted; mem_we never asserted.
//  4 Same stream as test 1 with in_valid toggled randomly ->
//    identical writes and word_count=2; in_ready=0 in every WRITE cycle.
//  5 rst pulsed after 2 data bytes -> all outputs 0, FSM=IDLE. Then rerun
//    test 1 -> correct writes starting at addr 0.
//  6 start pulsed during DATA -> ignored, load completes. Then start in
//    DONE -> load_done/cpu_run fall, a new image loads at addr 0.

Source files
------------

// File: rtl/mips_prog_loader.sv
// Boot-time program loader: turns a length-prefixed, big-endian byte stream
// into 32-bit instruction words, writes them into instruction memory from
// word 0, then releases the core via cpu_run.
module mips_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [15:0]       word_count,
  output logic              load_done,
  output logic              cpu_run,
  output logic              err_overflow
);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR
  } state_t;

  state_t            state, nxt;
  logic [7:0]        n_hi;
  logic [15:0]       n_words;
  logic [15:0]       hdr_n;
  logic [15:0]       wc_inc;
  logic [23:0]       word_sr;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] idx;
  logic              take;

  assign take    = in_valid && in_ready;
  assign hdr_n   = {n_hi, in_byte};
  assign wc_inc  = word_count + 16'd1;
  // The core is released exactly when the image is complete.
  assign cpu_run = load_done;

  // Next-state logic; start is only honoured in IDLE, DONE and ERROR.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = HDR_HI;
      HDR_HI:  if (take) nxt = HDR_LO;
      HDR_LO:  if (take) begin
                 if (hdr_n == 16'd0)                        nxt = DONE;
                 else if ({16'd0, hdr_n} > 32'(MAX_WORDS))  nxt = ERROR;
                 else                                       nxt = DATA;
               end
      DATA:    if (take && byte_cnt == 2'd3) nxt = WRITE;
      WRITE:   nxt = (wc_inc == n_words) ? DONE : DATA;
      DONE,
      ERROR:   if (start) nxt = HDR_HI;
      default: nxt = IDLE;
    endcase
  end

  // State register; status outputs are registered from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      load_done    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state        <= nxt;
      in_ready     <= (nxt == HDR_HI) || (nxt == HDR_LO) || (nxt == DATA);
      mem_we       <= (nxt == WRITE);
      load_done    <= (nxt == DONE);
      err_overflow <= (nxt == ERROR);
    end
  end

  // Datapath: header capture, word assembly, write address and counters.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      n_hi       <= '0;
      n_words    <= '0;
      word_sr    <= '0;
      byte_cnt   <= '0;
      idx        <= '0;
      word_count <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      // A fresh load always starts writing at word 0.
      if (nxt == HDR_HI && state != HDR_HI) begin
        word_count <= '0;
        idx        <= '0;
        byte_cnt   <= '0;
      end
      if (state == HDR_HI && take) n_hi    <= in_byte;
      if (state == HDR_LO && take) n_words <= hdr_n;
      if (state == DATA && take) begin
        word_sr  <= {word_sr[15:0], in_byte};
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          mem_wdata <= {word_sr, in_byte};
          mem_addr  <= idx;
        end
      end
      if (state == WRITE) begin
        idx        <= idx + 1'b1;
        word_count <= wc_inc;
      end
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: stream images in, watch memory writes.
module tb_mips_prog_loader;
  logic        clk1 = 1'b0;
  logic        rst  = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, load_done, cpu_run, err_overflow;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] word_count;

  int checks = 0;
  int passed = 0;
  logic [9:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  mips_prog_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
    .clk1(clk1), .rst(rst), .start(start), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .word_count(word_count),
    .load_done(load_done), .cpu_run(cpu_run), .err_overflow(err_overflow)
  );

  always #5 clk1 = ~clk1;

  // Record every write; in_ready must be low in each WRITE cycle.
  always @(negedge clk1) begin
    if (!rst && mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      checks++;
      if (in_ready !== 1'b0)
        $display("FAIL write_in_ready: got %b want 0", in_ready);
      else passed++;
    end
  end

  task automatic pulse_start();
    @(negedge clk1); start = 1'b1;
    @(negedge clk1); start = 1'b0;
  endtask

  // Send bytes; a byte moves on when in_valid && in_ready at the edge.
  task automatic send(input logic [7:0] b[$], input bit toggle);
    int i = 0;
    int cyc = 0;
    bit acc;
    while (i < b.size() && cyc < 500) begin
      @(negedge clk1);
      in_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      in_byte  = b[i];
      acc = in_valid && in_ready;
      @(posedge clk1);
      if (acc) i++;
      cyc++;
    end
    #1 in_valid = 1'b0;
    checks++;
    if (i != b.size()) $display("FAIL send_timeout: sent %0d want %0d", i, b.size());
    else passed++;
  endtask

  task automatic wait_done();
    int cyc = 0;
    @(negedge clk1);
    while (!load_done && cyc < 50) begin @(negedge clk1); cyc++; end
    checks++;
    if (!load_done) $display("FAIL done_timeout: load_done=%b want 1", load_done);
    else passed++;
  endtask

  task automatic check_img1(input string tag);
    checks++;
    if (wr_addr.size() != 2) begin
      $display("FAIL %s_nwrites: got %0d want 2", tag, wr_addr.size());
      return;
    end
    passed++;
    checks++;
    if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h2801000a)
      $display("FAIL %s_w0: got %0d/%h want 0/2801000a", tag, wr_addr[0], wr_data[0]);
    else passed++;
    checks++;
    if (wr_addr[1] !== 10'd1 || wr_data[1] !== 32'h28020014)
      $display("FAIL %s_w1: got %0d/%h want 1/28020014", tag, wr_addr[1], wr_data[1]);
    else passed++;
    checks++;
    if (word_count !== 16'd2 || cpu_run !== 1'b1 || load_done !== 1'b1)
      $display("FAIL %s_final: wc=%0d run=%b done=%b want 2/1/1", tag, word_count, cpu_run, load_done);
    else passed++;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if ({in_ready, mem_we, load_done, cpu_run, err_overflow} !== 5'b0 || word_count !== 16'd0)
      $display("FAIL %s: rdy/we/done/run/err=%b wc=%0d want 00000/0", tag,
               {in_ready, mem_we, load_done, cpu_run, err_overflow}, word_count);
    else passed++;
  endtask

  function automatic void img1(output logic [7:0] q[$]);
    q = '{8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h0a, 8'h28, 8'h02, 8'h00, 8'h14};
  endfunction

  task automatic test_reset();
    #2 check_idle("reset_outputs");
    @(negedge clk1); rst = 1'b0;
    @(negedge clk1);
    check_idle("idle_after_reset");
  endtask

  task automatic test_basic_load();
    logic [7:0] q[$];
    img1(q);
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send(q, 1'b0);
    wait_done();
    check_img1("basic");
  endtask

  task automatic test_empty();
    logic [7:0] q[$];
    q = '{8'h00, 8'h00};
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send(q, 1'b0);
    @(negedge clk1);
    checks++;
    if (load_done !== 1'b1 || cpu_run !== 1'b1 || word_count !== 16'd0 || wr_addr.size() != 0)
      $display("FAIL empty: done=%b run=%b wc=%0d writes=%0d want 1/1/0/0",
               load_done, cpu_run, word_count, wr_addr.size());
    else passed++;
  endtask

  task automatic test_overflow();
    logic [7:0] q[$];
    int acc = 0;
    q = '{8'h04, 8'h01};
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send(q, 1'b0);
    @(negedge clk1);
    checks++;
    if (err_overflow !== 1'b1 || in_ready !== 1'b0 || load_done !== 1'b0)
      $display("FAIL overflow_flag: err=%b rdy=%b done=%b want 1/0/0", err_overflow, in_ready, load_done);
    else passed++;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_byte = 8'hff;
      if (in_ready) acc++;
      @(negedge clk1);
    end
    in_valid = 1'b0;
    checks++;
    if (acc != 0 || wr_addr.size() != 0 || err_overflow !== 1'b1)
      $display("FAIL overflow_hold: accepted=%0d writes=%0d err=%b want 0/0/1", acc, wr_addr.size(), err_overflow);
    else passed++;
  endtask

  task automatic test_valid_toggle();
    logic [7:0] q[$];
    img1(q);
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    checks++;
    if (err_overflow !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL restart_from_error: err=%b rdy=%b want 0/1", err_overflow, in_ready);
    else passed++;
    send(q, 1'b1);
    wait_done();
    check_img1("toggle");
  endtask

  task automatic test_midload_reset();
    logic [7:0] q[$];
    q = '{8'h00, 8'h02, 8'h28, 8'h01};
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send(q, 1'b0);
    @(negedge clk1); rst = 1'b1;
    #1 check_idle("midload_reset");
    @(negedge clk1); rst = 1'b0;
    @(negedge clk1);
    check_idle("after_midload_reset");
    test_basic_load();
  endtask

  task automatic test_start_ignored_and_restart();
    logic [7:0] q[$];
    logic [7:0] a[$];
    logic [7:0] b[$];
    img1(q);
    a = q[0:3];
    b = q[4:9];
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send(a, 1'b0);
    pulse_start();
    send(b, 1'b0);
    wait_done();
    check_img1("start_in_data");
    // start from DONE clears the status and loads a fresh image at 0
    pulse_start();
    checks++;
    if (load_done !== 1'b0 || cpu_run !== 1'b0 || word_count !== 16'd0 || in_ready !== 1'b1)
      $display("FAIL restart_clear: done=%b run=%b wc=%0d rdy=%b want 0/0/0/1",
               load_done, cpu_run, word_count, in_ready);
    else passed++;
    wr_addr.delete(); wr_data.delete();
    q = '{8'h00, 8'h01, 8'hde, 8'had, 8'hbe, 8'hef};
    send(q, 1'b0);
    wait_done();
    checks++;
    if (wr_addr.size() != 1 || word_count !== 16'd1)
      $display("FAIL restart_count: writes=%0d wc=%0d want 1/1", wr_addr.size(), word_count);
    else begin
      passed++;
      checks++;
      if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'hdeadbeef)
        $display("FAIL restart_word: got %0d/%h want 0/deadbeef", wr_addr[0], wr_data[0]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_empty();
    test_overflow();
    test_valid_toggle();
    test_midload_reset();
    test_start_ignored_and_restart();
    repeat (2) @(negedge clk1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
